// File: rtl/input_dev_pkg.sv
// rtl/input_dev_pkg.sv - shared constants and types for input-device sampling
package input_dev_pkg;

    localparam int DEVICE_WIDTH            = 32;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    // Settle counter holds 0..cycles-1 with one spare bit so it can never wrap.
    function automatic int debounce_count_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/input_device_sampler_sync_chain.sv
// rtl/input_device_sampler_sync_chain.sv - plain multi-flop synchronizer chain
module sync_chain #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/input_device_sampler.sv
// rtl/input_device_sampler.sv - synchronize, debounce and commit one device's raw pins
module input_device_sampler
    import input_dev_pkg::*;
#(
    parameter int               WIDTH           = DEVICE_WIDTH,
    parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             read_strobe,
    output logic [WIDTH-1:0] device_values,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam int            CW         = debounce_count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    count;
    state_t           state;
    state_t           next_state;
    logic             mismatch;
    logic             commit;
    logic             advance;
    logic             commit_event;

    sync_chain #(
        .WIDTH       (WIDTH),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (mismatch) begin
            next_state = SETTLING;
        end else if (commit) begin
            next_state = STABLE;
        end
    end

    // A new synchronized value always wins over finishing the current settle.
    always_comb begin
        mismatch     = (sync_out != candidate);
        commit       = 1'b0;
        advance      = 1'b0;
        if (!mismatch && state == SETTLING) begin
            commit  = (count == LAST_COUNT);
            advance = (count != LAST_COUNT);
        end
        diff         = candidate ^ device_values;
        commit_event = commit && (diff != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate     <= RESET_VALUE;
            count         <= '0;
            device_values <= RESET_VALUE;
            changed       <= 1'b0;
            change_mask   <= '0;
        end else begin
            if (mismatch) begin
                candidate <= sync_out;
                count     <= '0;
            end else if (advance) begin
                count <= count + 1'b1;
            end

            if (commit) begin
                device_values <= candidate;
            end

            // A commit landing on the read edge is a fresh event; older bits were consumed.
            if (commit_event) begin
                changed     <= 1'b1;
                change_mask <= read_strobe ? diff : (change_mask | diff);
            end else if (read_strobe) begin
                changed     <= 1'b0;
                change_mask <= '0;
            end
        end
    end

endmodule

// File: tb/tb_input_device_sampler.sv
// tb/tb_input_device_sampler.sv - scoreboard bench for input_device_sampler
module tb_input_device_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] raw_in;
    logic        read_strobe;
    logic [31:0] device_values;
    logic        changed;
    logic [31:0] change_mask;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] dv;
        logic        ch;
        logic [31:0] mask;
    } exp_t;

    exp_t sb[$];

    input_device_sampler dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .read_strobe   (read_strobe),
        .device_values (device_values),
        .changed       (changed),
        .change_mask   (change_mask)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] dv, input logic ch,
                        input logic [31:0] mask);
        exp_t e;
        e.tag  = tag;
        e.dv   = dv;
        e.ch   = ch;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_empty: got size %0d expected nonzero", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            assert (device_values === e.dv) else begin
                miscompares++;
                $error("FAIL %s device_values: got %h expected %h", e.tag, device_values, e.dv);
            end
            vectors++;
            assert (changed === e.ch) else begin
                miscompares++;
                $error("FAIL %s changed: got %b expected %b", e.tag, changed, e.ch);
            end
            vectors++;
            assert (change_mask === e.mask) else begin
                miscompares++;
                $error("FAIL %s change_mask: got %h expected %h", e.tag, change_mask, e.mask);
            end
        end
    endtask

    task automatic pulse_read();
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
    endtask

    initial begin
        logic [31:0] m;

        reset       = 1'b1;
        raw_in      = 32'hE5F84AB1;
        read_strobe = 1'b0;
        push("reset_async", 32'h0, 1'b0, 32'h0);
        #1;
        check_pop();
        tick(2);

        reset = 1'b0;
        push("latency_edge6", 32'h0, 1'b0, 32'h0);
        tick(6);
        check_pop();
        push("latency_edge7", 32'hE5F84AB1, 1'b1, 32'hE5F84AB1);
        tick(1);
        check_pop();

        push("clear", 32'hE5F84AB1, 1'b0, 32'h0);
        pulse_read();
        check_pop();

        raw_in = 32'h5C8C6A01;
        m      = 32'hE5F84AB1 ^ 32'h5C8C6A01;
        push("glitch_setup", 32'h5C8C6A01, 1'b1, m);
        tick(10);
        check_pop();
        raw_in = 32'h5C8C6A00;
        push("glitch_mid", 32'h5C8C6A01, 1'b1, m);
        tick(2);
        check_pop();
        raw_in = 32'h5C8C6A01;
        push("glitch_after", 32'h5C8C6A01, 1'b1, m);
        tick(12);
        check_pop();

        raw_in = 32'h0;
        tick(10);
        push("accum_zero", 32'h0, 1'b0, 32'h0);
        pulse_read();
        check_pop();
        raw_in = 32'h1;
        push("accum_first", 32'h1, 1'b1, 32'h1);
        tick(10);
        check_pop();
        raw_in = 32'h3;
        push("accum_second", 32'h3, 1'b1, 32'h3);
        tick(10);
        check_pop();

        raw_in = 32'h1;
        tick(10);
        push("simul_setup", 32'h1, 1'b0, 32'h0);
        pulse_read();
        check_pop();
        raw_in = 32'h5;
        push("simul_edge6", 32'h1, 1'b0, 32'h0);
        tick(6);
        check_pop();
        push("simul_commit", 32'h5, 1'b1, 32'h4);
        pulse_read();
        check_pop();

        raw_in = 32'hFFFF0000;
        tick(4);
        reset = 1'b1;
        push("reset_mid_settle", 32'h0, 1'b0, 32'h0);
        #1;
        check_pop();
        tick(2);
        reset = 1'b0;
        push("post_reset_edge6", 32'h0, 1'b0, 32'h0);
        tick(6);
        check_pop();
        push("post_reset_edge7", 32'hFFFF0000, 1'b1, 32'hFFFF0000);
        tick(1);
        check_pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
